// File: rtl/hack_ctrl_pkg.sv
// Shared definitions for the Hack CPU control core: FSM encodings, instruction
// field positions and the ALU control bundle.
package hack_ctrl_pkg;

    typedef logic [2:0] hack_state_t;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_FETCH  = 3'd1;
    localparam logic [2:0] ST_DECODE = 3'd2;
    localparam logic [2:0] ST_MRD    = 3'd3;
    localparam logic [2:0] ST_EXEC   = 3'd4;
    localparam logic [2:0] ST_MWR    = 3'd5;

    // Bit positions inside a Hack instruction word.
    localparam int CINSTR  = 15;
    localparam int A_BIT   = 12;
    localparam int CTRL_HI = 11;
    localparam int CTRL_LO = 6;
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;
    localparam int JLT     = 2;
    localparam int JEQ     = 1;
    localparam int JGT     = 0;

    typedef struct packed {
        logic zx;
        logic nx;
        logic zy;
        logic ny;
        logic f;
        logic no;
    } alu_ctrl_t;

endpackage

// File: rtl/hack_jump_unit.sv
// Resolves the Hack jump condition from the instruction's jump bits and the
// ALU's zero/negative flags.
module hack_jump_unit
    import hack_ctrl_pkg::*;
(
    input  logic [2:0] i_jmp,
    input  logic       i_zr,
    input  logic       i_ng,
    output logic       o_take
);

    logic w_lt;
    logic w_eq;
    logic w_gt;

    assign w_lt = i_jmp[JLT] & i_ng;
    assign w_eq = i_jmp[JEQ] & i_zr;
    assign w_gt = i_jmp[JGT] & ~i_ng & ~i_zr;

    assign o_take = w_lt | w_eq | w_gt;

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/datapath core driving an external Hack ALU.
// Optional macro HACK_RETIRE_CNT_EN adds a 32-bit retired-instruction counter.
module hack_cpu_ctrl
    import hack_ctrl_pkg::*;
#(
    parameter int unsigned       PC_W         = 15,
    parameter logic [PC_W-1:0]   RESET_VECTOR = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic [15:0]     imem_rdata,
    input  logic            imem_ack,
    output logic            dmem_req,
    output logic            dmem_we,
    output logic [PC_W-1:0] dmem_addr,
    output logic [15:0]     dmem_wdata,
    input  logic [15:0]     dmem_rdata,
    input  logic            dmem_ack,
    output logic [15:0]     alu_x,
    output logic [15:0]     alu_y,
    output logic [5:0]      alu_ctrl,
    input  logic [15:0]     alu_out,
    input  logic            alu_zr,
    input  logic            alu_ng,
    output logic [PC_W-1:0] pc,
    output logic [2:0]      o_dbg_state
`ifdef HACK_RETIRE_CNT_EN
    ,
    output logic [31:0]     retired
`endif
);

    hack_state_t     r_state;
    logic [15:0]     r_a;
    logic [15:0]     r_d;
    logic [15:0]     r_ir;
    logic [15:0]     r_mdr;
    logic [15:0]     r_res;
    logic [PC_W-1:0] r_waddr;
    logic [PC_W-1:0] r_pc;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_a_addr;
    logic            w_take;
    logic            w_imem_xfer;
    logic            w_dmem_xfer;
    alu_ctrl_t       w_ctrl;

    // Handshake: req is a pure decode of state and addr/wdata come from registers
    // that only change on a state exit, so they are stable while req is high; a
    // beat transfers on any rising edge with req && ack (same-cycle ack allowed),
    // and ack without req is ignored.
    assign w_imem_xfer = imem_req & imem_ack;
    assign w_dmem_xfer = dmem_req & dmem_ack;

    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_a_addr = r_a[PC_W-1:0];
    assign w_ctrl   = r_ir[CTRL_HI:CTRL_LO];

    hack_jump_unit u_jump (
        .i_jmp  (r_ir[JLT:JGT]),
        .i_zr   (alu_zr),
        .i_ng   (alu_ng),
        .o_take (w_take)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_a     <= '0;
            r_d     <= '0;
            r_ir    <= '0;
            r_mdr   <= '0;
            r_res   <= '0;
            r_waddr <= '0;
            r_pc    <= RESET_VECTOR;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                end
                ST_FETCH: begin
                    if (w_imem_xfer) begin
                        r_ir    <= imem_rdata;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    if (!r_ir[CINSTR]) begin
                        r_a     <= {1'b0, r_ir[14:0]};
                        r_pc    <= w_pc_inc;
                        r_state <= ST_FETCH;
                    end else if (r_ir[A_BIT]) begin
                        r_state <= ST_MRD;
                    end else begin
                        r_state <= ST_EXEC;
                    end
                end
                ST_MRD: begin
                    if (w_dmem_xfer) begin
                        r_mdr   <= dmem_rdata;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // Store address and jump target both use A from before this instruction.
                    r_waddr <= w_a_addr;
                    r_res   <= alu_out;
                    if (r_ir[DEST_A]) r_a <= alu_out;
                    if (r_ir[DEST_D]) r_d <= alu_out;
                    r_pc    <= w_take ? w_a_addr : w_pc_inc;
                    r_state <= r_ir[DEST_M] ? ST_MWR : ST_FETCH;
                end
                ST_MWR: begin
                    if (w_dmem_xfer) begin
                        r_state <= ST_FETCH;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign imem_req    = (r_state == ST_FETCH);
    assign imem_addr   = r_pc;
    assign dmem_req    = (r_state == ST_MRD) || (r_state == ST_MWR);
    assign dmem_we     = (r_state == ST_MWR);
    assign dmem_addr   = (r_state == ST_MWR) ? r_waddr : w_a_addr;
    assign dmem_wdata  = r_res;
    assign alu_x       = r_d;
    assign alu_y       = r_ir[A_BIT] ? r_mdr : r_a;
    assign alu_ctrl    = w_ctrl;
    assign pc          = r_pc;
    assign o_dbg_state = r_state;

`ifdef HACK_RETIRE_CNT_EN
    logic [31:0] r_retired;
    logic        w_retire;

    assign w_retire = ((r_state == ST_DECODE) && !r_ir[CINSTR])
                   || ((r_state == ST_EXEC) && !r_ir[DEST_M])
                   || ((r_state == ST_MWR) && w_dmem_xfer);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retired <= '0;
        end else if (w_retire) begin
            r_retired <= r_retired + 32'd1;
        end
    end

    assign retired = r_retired;
`endif

endmodule

// File: doc/hack_cpu_ctrl.md
Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU control/datapath core that drives the Hack ALU: owns A, D, PC and IR, and issues the zx/nx/zy/ny/f/no controls and x/y operands.
- Consumes the ALU's out/zr/ng to write registers and memory and to resolve jumps.
- ALU stays a separate instance wired at the top level. Instruction and data memories attach through req/ack handshakes.

Parameters:
- PC_W, 15, width of PC and of memory addresses.
- RESET_VECTOR, 0, PC value loaded on reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  instruction fetch request.
- imem_addr  out  PC_W  fetch address, equals pc.
- imem_rdata  in  16  instruction word, valid with imem_ack.
- imem_ack  in  1  fetch complete.
- dmem_req  out  1  data access request.
- dmem_we  out  1  1 = write, 0 = read.
- dmem_addr  out  PC_W  data address.
- dmem_wdata  out  16  write data.
- dmem_rdata  in  16  read data, valid with dmem_ack.
- dmem_ack  in  1  data access complete.
- alu_x  out  16  ALU x operand, always D.
- alu_y  out  16  ALU y operand: MDR if IR[12] else A.
- alu_ctrl  out  6  {zx,nx,zy,ny,f,no} = IR[11:6].
- alu_out  in  16  ALU result.
- alu_zr  in  1  ALU zero flag.
- alu_ng  in  1  ALU negative flag.
- pc  out  PC_W  current program counter.

Behaviour:
- States:
  - IDLE: reset state; leaves to FETCH on the first clock after rst_n releases.
  - FETCH, DECODE, MRD, EXEC, MWR.
- Reset (async, rst_n low):
  - state=IDLE; A=D=IR=MDR=RES=WADDR=0; pc=RESET_VECTOR.
  - imem_req=dmem_req=dmem_we=0 immediately.
  - alu_x=0; alu_ctrl=0.
- Handshake:
  - req is decoded from state: imem_req=(FETCH); dmem_req=(MRD|MWR); dmem_we=(MWR).
  - addr and wdata stay stable while req is high.
  - Transfer occurs on any clock edge where req and ack are both high; same-cycle ack is legal.
  - ack while req is low is ignored.
- FETCH: on imem_ack, IR<=imem_rdata, go to DECODE.
- DECODE:
  - IR[15]=0 (A-instruction): A<={0,IR[14:0]}, pc<=pc+1, go to FETCH.
  - IR[15]=1: go to MRD if IR[12]=1, else EXEC.
  - IR[14:13] are ignored.
- MRD: dmem_addr=A[PC_W-1:0]; on dmem_ack, MDR<=dmem_rdata, go to EXEC.
- EXEC (single cycle, ALU sampled combinationally):
  - WADDR<=old A; RES<=alu_out.
  - If IR[5]: A<=alu_out. If IR[4]: D<=alu_out.
  - take = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~ng&~zr).
  - pc <= take ? old A[PC_W-1:0] : pc+1.
  - Next state: MWR if IR[3], else FETCH.
- MWR: dmem_addr=WADDR, wdata=RES; on dmem_ack go to FETCH.
- Hack semantics: the M address and jump target always use A as it was before the instruction, even when A is also a destination.
- Latency with zero-wait memory:
  - A-instruction: 2 cycles.
  - C-instruction: 3 cycles, +1 if M is read, +1 if M is written.
- PC wraps from 2^PC_W-1 to 0, no flag.
- Reset mid-access abandons the transaction; no partial register update.

Optional Feature:
- Macro HACK_RETIRE_CNT_EN.
- When defined: extra output retired (32 bits), reset to 0, +1 on each DECODE of an A-instruction and on each C-instruction completing (EXEC→FETCH or MWR ack); wraps at 2^32.
- When undefined: port and counter are absent.

Decomposition:
- Package hack_ctrl_pkg: state enum; IR field constants (A_BIT=12, CTRL_HI/LO=11/6, DEST_A/D/M=5/4/3, JLT/JEQ/JGT=2/1/0, CINSTR=15); alu_ctrl_t.
- One sub-module: hack_jump_unit (combinational jump bits + zr/ng → take).

Test Plan:
- Fetch 0x0005, 0xEC10 (D=A) → A=5, D=5, pc=2, alu_ctrl=6'b110000 during EXEC; 5 cycles total with zero-wait memory.
- @7, D=A, @3, 0xE090 (D=D+A) → D=10, alu_ctrl=6'b000010, pc=4.
- A=100, D=7, 0xE328 (AM=D) → one dmem write with addr=100 and wdata=7, then A=7.
- D=0, @20, 0xE302 (D;JEQ) → pc=20. With D=5 → pc=pc+1. With D=0xFFFF and 0xE304 (JLT) → jump taken.
- A=100, 0xFC10 (D=M), dmem_ack delayed 3 cycles → dmem_req held with addr=100 and we=0; D=dmem_rdata after ack.
- Assert rst_n low mid-MWR → dmem_req drops asynchronously; after release pc=0, state IDLE→FETCH, no write is committed.
